// File: rtl/param_call_stack.sv
// Return-address LIFO for the MCU sequencer: configurable width/depth, replace-top,
// sticky overflow/underflow flags, reject-or-wrap overflow policy and synchronous flush.
module param_call_stack #(
  parameter int DW   = 11,
  parameter int AW   = 4,
  parameter bit WRAP = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic          err_clr,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic [AW:0]   count,
  output logic          empty,
  output logic          full,
  output logic          overflow,
  output logic          underflow
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] top, top_next, wr_addr;
  logic [AW:0]   cnt_next;
  logic          wr_en, ovf_evt, unf_evt;

  assign empty = (count == '0);
  assign full  = (count == CNT_FULL);
  // Gating on empty keeps a stale top from ever reaching the PC mux.
  assign dout  = empty ? '0 : mem[top];

  always_comb begin
    top_next = top;
    cnt_next = count;
    wr_en    = 1'b0;
    wr_addr  = top + PTR_ONE;
    ovf_evt  = 1'b0;
    unf_evt  = 1'b0;
    if (flush) begin
      top_next = '1;
      cnt_next = '0;
    end else if (push && pop) begin
      if (empty) begin
        // Pop half underflows; the push half still lands as the only entry.
        unf_evt  = 1'b1;
        wr_en    = 1'b1;
        top_next = top + PTR_ONE;
        cnt_next = CNT_ONE;
      end else begin
        wr_en   = 1'b1;
        wr_addr = top;
      end
    end else if (push) begin
      if (!full) begin
        wr_en    = 1'b1;
        top_next = top + PTR_ONE;
        cnt_next = count + CNT_ONE;
      end else begin
        ovf_evt = 1'b1;
        if (WRAP) begin
          wr_en    = 1'b1;
          top_next = top + PTR_ONE;
        end
      end
    end else if (pop) begin
      if (!empty) begin
        top_next = top - PTR_ONE;
        cnt_next = count - CNT_ONE;
      end else begin
        unf_evt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      top       <= '1;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      top       <= top_next;
      count     <= cnt_next;
      // A fresh error wins over a simultaneous clear.
      overflow  <= ovf_evt | (overflow & ~err_clr);
      underflow <= unf_evt | (underflow & ~err_clr);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_en) mem[wr_addr] <= din;
  end

endmodule
